em_readout: RTL and testbench

EM_READOUT -- requirements
Module: em_readout

---
 rtl/lvda_pkg.sv | 20 ++
 rtl/em_shift_ctr.sv | 30 +++
 rtl/em_readout.sv | 126 ++++++++++++
 tb/tb_em_readout.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvda_pkg.sv
// Shared LVDA definitions: error-monitor readout defaults, state encoding and
// a counter-width helper used by the serializers.
package lvda_pkg;

  localparam int EM_WIDTH  = 26;
  localparam int EM_CLRLEN = 2;

  typedef enum logic [2:0] {
    EM_IDLE    = 3'd0,
    EM_CAPTURE = 3'd1,
    EM_SHIFT   = 3'd2,
    EM_CLEAR   = 3'd3,
    EM_DONE    = 3'd4
  } em_state_t;

  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/em_shift_ctr.sv
// V1-enabled down-counter with synchronous load and terminal-count flag.
// Holds at zero rather than wrapping, so a late decrement is harmless.
module em_shift_ctr #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          v1,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (v1) begin
      if (load) begin
        count <= load_val;
      end else if (dec && !tc) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/em_readout.sv
// Error monitor readout: snapshots the active-low EM latches on RDEM, shifts
// the word out MSB first on V1 cells, then optionally requests a clear.
module em_readout
  import lvda_pkg::*;
#(
  parameter int WIDTH  = EM_WIDTH,
  parameter int CLRLEN = EM_CLRLEN
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             V1,
  input  logic [WIDTH-1:0] EMN,
  input  logic             RDEM,
  input  logic             CLRINH,
  output logic             SERDAT,
  output logic             SERVAL,
  output logic             BUSY,
  output logic             EMCLR,
  output logic             ANYERR,
  output logic             LATE,
  output logic [2:0]       dbg_state
);

  localparam int CW = ctr_width((WIDTH > CLRLEN) ? WIDTH : CLRLEN);

  // Handshake: RDEM is a one-cycle request accepted only in IDLE; BUSY is the
  // busy/not-ready indication, SERVAL qualifies SERDAT for the current V1 cell.

  em_state_t        state, state_nxt;
  logic [WIDTH-1:0] snap;
  logic             late_q;
  logic             snap_load;
  logic             late_set;
  logic             ctr_load;
  logic             ctr_dec;
  logic [CW-1:0]    ctr_val;
  logic [CW-1:0]    ctr_count;
  logic             ctr_tc;

  em_shift_ctr #(.CW(CW)) u_ctr (
    .clk      (SIM_CLK),
    .rst_n    (SIM_RST),
    .v1       (V1),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .count    (ctr_count),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    late_set  = 1'b0;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    ctr_val   = '0;
    case (state)
      EM_IDLE: begin
        if (RDEM) state_nxt = EM_CAPTURE;
      end
      EM_CAPTURE: begin
        if (V1) begin
          snap_load = 1'b1;
          ctr_load  = 1'b1;
          ctr_val   = CW'(WIDTH - 1);
          state_nxt = EM_SHIFT;
        end
      end
      EM_SHIFT: begin
        if (V1) begin
          if (ctr_tc) begin
            if (!CLRINH) begin
              ctr_load  = 1'b1;
              ctr_val   = CW'(CLRLEN - 1);
              state_nxt = EM_CLEAR;
            end else begin
              state_nxt = EM_DONE;
            end
          end else begin
            ctr_dec = 1'b1;
          end
        end
      end
      EM_CLEAR: begin
        if (V1) begin
          // Errors not in the snapshot are wiped by this clear without being read.
          late_set = |(~EMN & ~snap);
          if (ctr_tc) state_nxt = EM_DONE;
          else        ctr_dec   = 1'b1;
        end
      end
      EM_DONE: begin
        state_nxt = EM_IDLE;
      end
      default: begin
        state_nxt = EM_IDLE;
      end
    endcase
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state  <= EM_IDLE;
      snap   <= '0;
      late_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (snap_load) begin
        snap   <= ~EMN;
        late_q <= 1'b0;
      end else if (late_set) begin
        late_q <= 1'b1;
      end
    end
  end

  assign SERVAL    = (state == EM_SHIFT);
  assign SERDAT    = SERVAL & snap[ctr_count];
  assign BUSY      = (state == EM_CAPTURE) || (state == EM_SHIFT) || (state == EM_CLEAR);
  assign EMCLR     = (state == EM_CLEAR);
  assign ANYERR    = |(~EMN);
  assign LATE      = late_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_em_readout.sv
// Self-checking bench for em_readout: scenario tasks compared against a
// word-level model (expected word = inverted EMN at capture).
module tb_em_readout;

  localparam int W      = 26;
  localparam int CLRLEN = 2;

  logic         clk;
  logic         rst_n;
  logic         v1;
  logic [W-1:0] emn;
  logic         rdem;
  logic         clrinh;
  logic         serdat;
  logic         serval;
  logic         busy;
  logic         emclr;
  logic         anyerr;
  logic         late;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic stall = 1'b0;

  // Scoreboard: expected words, and what the monitor observed
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_word;
  int           obs_n;
  int           clr_cnt;
  int           busy_falls;
  int           serval_cycles;
  logic         busy_prev;

  em_readout #(.WIDTH(W), .CLRLEN(CLRLEN)) dut (
    .SIM_CLK   (clk),
    .SIM_RST   (rst_n),
    .V1        (v1),
    .EMN       (emn),
    .RDEM      (rdem),
    .CLRINH    (clrinh),
    .SERDAT    (serdat),
    .SERVAL    (serval),
    .BUSY      (busy),
    .EMCLR     (emclr),
    .ANYERR    (anyerr),
    .LATE      (late),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // V1 strobe: one clock wide, every fourth clock, suppressed while stalled
  initial begin
    int phase;
    phase = 0;
    v1 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase = (phase + 1) % 4;
      v1 = (phase == 0) && !stall;
    end
  end

  // Monitor, sampling on the falling edge
  initial begin
    obs_word = '0; obs_n = 0; clr_cnt = 0; busy_falls = 0;
    serval_cycles = 0; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (v1 && serval) begin
        obs_word = {obs_word[W-2:0], serdat};
        obs_n++;
      end
      if (v1 && emclr) clr_cnt++;
      if (serval) serval_cycles++;
      if (busy_prev && !busy) busy_falls++;
      busy_prev = busy;
    end
  end

  // Driver tasks
  task automatic start_read(input logic [W-1:0] e, input logic ci);
    @(posedge clk);
    #2;
    emn = e;
    clrinh = ci;
    obs_word = '0; obs_n = 0; clr_cnt = 0; busy_falls = 0;
    busy_prev = busy;
    exp_q.push_back(~e);
    rdem = 1'b1;
    @(posedge clk);
    #2;
    rdem = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b still high after %0d cycles, required 0", tag, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_obs(input int target, input string tag);
    int n;
    n = 0;
    while (obs_n < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_n < target) begin
      errors++;
      $display("FAIL %s_obs_timeout: cells=%0d, required %0d", tag, obs_n, target);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic [W-1:0] e;
    repeat (3) @(negedge clk);
    checks++;
    if ({serdat, serval, busy, emclr, late} !== 5'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: dat/val/busy/clr/late=%b state=%0d, required 00000 state 0",
               {serdat, serval, busy, emclr, late}, dbg_state);
    end
    checks++;
    if (anyerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_anyerr_clean: anyerr=%b, required 0", anyerr);
    end
    e = '1;
    e[$urandom_range(0, W-1)] = 1'b0;
    emn = e;
    #1;
    checks++;
    if (anyerr !== 1'b1) begin
      errors++;
      $display("FAIL reset_anyerr_live: anyerr=%b, required 1", anyerr);
    end
    emn = '1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_clear();
    logic [W-1:0] e, exp;
    e = '1;
    e[0] = 1'b0;
    e[W-1] = 1'b0;
    start_read(e, 1'b0);
    wait_idle("read_clear");
    exp = exp_q.pop_front();
    checks++;
    if (obs_n !== W || obs_word !== exp || exp !== 26'h2000001) begin
      errors++;
      $display("FAIL read_clear_word: cells=%0d word=%h, required %0d cells word %h", obs_n, obs_word, W, exp);
    end
    checks++;
    if (clr_cnt !== CLRLEN) begin
      errors++;
      $display("FAIL read_clear_emclr: emclr strobes=%0d, required %0d", clr_cnt, CLRLEN);
    end
    checks++;
    if (late !== 1'b0 || busy_falls !== 1) begin
      errors++;
      $display("FAIL read_clear_flags: late=%b busy_falls=%0d, required 0 and 1", late, busy_falls);
    end
  endtask

  task automatic test_read_noclear();
    logic [W-1:0] e, exp;
    e = '1;
    e[0] = 1'b0;
    e[W-1] = 1'b0;
    start_read(e, 1'b1);
    wait_idle("read_noclear");
    exp = exp_q.pop_front();
    checks++;
    if (obs_n !== W || obs_word !== exp) begin
      errors++;
      $display("FAIL read_noclear_word: cells=%0d word=%h, required %0d cells word %h", obs_n, obs_word, W, exp);
    end
    checks++;
    if (clr_cnt !== 0) begin
      errors++;
      $display("FAIL read_noclear_emclr: emclr strobes=%0d, required 0", clr_cnt);
    end
  endtask

  task automatic test_late();
    logic [W-1:0] exp;
    start_read('1, 1'b0);
    wait_obs(10, "late");
    @(posedge clk);
    #2;
    checks++;
    if (anyerr !== 1'b0 || late !== 1'b0) begin
      errors++;
      $display("FAIL late_before: anyerr=%b late=%b, required 0 0", anyerr, late);
    end
    emn[5] = 1'b0;
    #1;
    checks++;
    if (anyerr !== 1'b1) begin
      errors++;
      $display("FAIL late_anyerr: anyerr=%b, required 1", anyerr);
    end
    wait_idle("late");
    exp = exp_q.pop_front();
    checks++;
    if (obs_n !== W || obs_word !== exp || obs_word[5] !== 1'b0) begin
      errors++;
      $display("FAIL late_word: cells=%0d word=%h, required %0d cells word %h", obs_n, obs_word, W, exp);
    end
    checks++;
    if (late !== 1'b1) begin
      errors++;
      $display("FAIL late_flag: late=%b, required 1", late);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (late !== 1'b1) begin
      errors++;
      $display("FAIL late_sticky: late=%b, required 1", late);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, exp;
    logic ci;
    for (int i = 0; i < 8; i++) begin
      e  = W'($urandom);
      ci = 1'($urandom_range(0, 1));
      start_read(e, ci);
      #1;
      checks++;
      if (anyerr !== (e != '1)) begin
        errors++;
        $display("FAIL rand%0d_anyerr: anyerr=%b, required %b", i, anyerr, (e != '1));
      end
      wait_idle("rand");
      exp = exp_q.pop_front();
      checks++;
      if (obs_n !== W || obs_word !== exp) begin
        errors++;
        $display("FAIL rand%0d_word: cells=%0d word=%h, required %0d cells word %h", i, obs_n, obs_word, W, exp);
      end
      checks++;
      if (clr_cnt !== (ci ? 0 : CLRLEN) || late !== 1'b0 || busy_falls !== 1) begin
        errors++;
        $display("FAIL rand%0d_flags: emclr=%0d late=%b busy_falls=%0d, required %0d 0 1",
                 i, clr_cnt, late, busy_falls, ci ? 0 : CLRLEN);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, exp;
    e = W'($urandom);
    start_read(e, 1'b0);
    wait_obs(5, "b2b");
    @(posedge clk);
    #2;
    rdem = 1'b1;
    @(posedge clk);
    #2;
    rdem = 1'b0;
    wait_idle("b2b");
    repeat (200) @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (obs_n !== W || obs_word !== exp) begin
      errors++;
      $display("FAIL b2b_word: cells=%0d word=%h, required %0d cells word %h", obs_n, obs_word, W, exp);
    end
    checks++;
    if (busy_falls !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: busy_falls=%0d busy=%b, required 1 and 0", busy_falls, busy);
    end
  endtask

  task automatic test_reset_mid();
    start_read(W'($urandom), 1'b0);
    wait_obs(13, "rst_mid");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({serdat, serval, busy, emclr, late} !== 5'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: dat/val/busy/clr/late=%b state=%0d, required 00000 state 0",
               {serdat, serval, busy, emclr, late}, dbg_state);
    end
    void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    serval_cycles = 0;
    repeat (200) @(negedge clk);
    checks++;
    if (serval_cycles !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: serval cycles=%0d busy=%b, required 0 and 0", serval_cycles, busy);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e, exp;
    int hold_n;
    int bad;
    e = W'($urandom);
    start_read(e, 1'b0);
    exp = ~e;
    wait_obs(8, "stall");
    stall = 1'b1;
    repeat (3) @(negedge clk);
    hold_n = obs_n;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (serval !== 1'b1 || serdat !== exp[W-1-hold_n] || obs_n !== hold_n) begin
        errors++;
        bad++;
        if (bad <= 3)
          $display("FAIL stall_hold: cycle %0d val=%b dat=%b cells=%0d, required 1 %b %0d",
                   i, serval, serdat, obs_n, exp[W-1-hold_n], hold_n);
      end
    end
    stall = 1'b0;
    wait_idle("stall");
    exp = exp_q.pop_front();
    checks++;
    if (obs_n !== W || obs_word !== exp) begin
      errors++;
      $display("FAIL stall_word: cells=%0d word=%h, required %0d cells word %h", obs_n, obs_word, W, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rdem   = 1'b0;
    clrinh = 1'b0;
    emn    = '1;
    test_reset();
    test_read_clear();
    test_read_noclear();
    test_late();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
